dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the pipeline MEM stage and an external loader/debug port. Sits between the MEM stage register logic and the data memory instance: the CPU keeps priority, and the loader is served in idle CPU cycles, in a forced slot after a bounded wait, or under an explicit lock. Guarantees loader forward progress and single-owner memory access.

## Interface
- ADDRESS_LINE, 8, memory address width
- MAX_WAIT, 4, loader wait cycles before a forced slot; legal range 1..15

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  MEM stage access this cycle (mem_read | mem_write)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDRESS_LINE  CPU address (ALU result)
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  memory read data to the MEM stage (combinational)
- cpu_stall  out  1  freezes PC and IF/ID/EX/MEM registers
- ldr_valid  in  1  loader request
- ldr_lock  in  1  loader requests exclusive ownership
- ldr_we  in  1  loader write/read select
- ldr_addr  in  ADDRESS_LINE  loader address
- ldr_wdata  in  8  loader write data
- ldr_ready  out  1  loader request accepted this cycle
- ldr_rvalid  out  1  loader read data valid, one-cycle pulse
- ldr_rdata  out  8  loader read data
- mem_addr, mem_wdata  out  ADDRESS_LINE / 8  to the data memory
- mem_write, mem_read  out  1  to the data memory
- mem_rdata  in  8  combinational read data from the data memory

## Operation
- FSM states: CPU_OWN (reset state), LDR_SLOT, LDR_LOCK.
- CPU_OWN: the CPU owns the memory when cpu_req=1. If cpu_req=0 and ldr_valid=1, the loader is granted the same cycle (ldr_ready=1) and the state does not change.
- wait_cnt (4 bits): increments each cycle ldr_valid=1 and ldr_ready=0, saturating at MAX_WAIT; clears on any loader acceptance or when ldr_valid=0.
- CPU_OWN -> LDR_SLOT when ldr_valid=1, cpu_req=1, and wait_cnt=MAX_WAIT-1.
- LDR_SLOT: cpu_stall=1; the loader is granted (ldr_ready=ldr_valid); always returns to CPU_OWN next cycle.
- CPU_OWN -> LDR_LOCK when ldr_lock=1 and cpu_req=0; with cpu_req=1, the lock waits for an idle CPU cycle or a forced LDR_SLOT, which then enters LDR_LOCK.
- LDR_LOCK: cpu_stall=1 continuously; the loader is granted every valid cycle; exits to CPU_OWN the cycle after ldr_lock=0.
- Mux: the granted requester drives mem_addr/mem_wdata; mem_write/mem_read=valid&we/valid&!we of the granted side. With no grant, all are 0 and the address holds 0.
- cpu_rdata=mem_rdata always; it is meaningful only when the CPU is granted.
- Loader read accepted: ldr_rdata<=mem_rdata and ldr_rvalid<=1 at that edge; otherwise ldr_rvalid<=0 and ldr_rdata holds. Loader writes produce no response.
- The loader must hold ldr_valid and its payload until ldr_ready=1. Dropping ldr_valid early is legal and clears wait_cnt.

## Timing
- Reset (reset_n=0, asynchronous): state=CPU_OWN, wait_cnt=0, ldr_rvalid=0, ldr_rdata=0. While reset is asserted, ldr_ready=0, cpu_stall=0, and mem_write=mem_read=0.
- Grant is combinational, in the same cycle. Memory write commits at the accepting edge.
- Loader read latency: 1 cycle from acceptance to ldr_rvalid.
- Worst-case loader wait with a busy CPU: MAX_WAIT cycles. The CPU loses exactly 1 cycle per forced slot.
- Simultaneous ldr_lock rise and forced slot: LDR_SLOT is taken first, then LDR_LOCK.
- Reset asserted mid-lock releases the stall immediately. Any pending ldr_rvalid is dropped.

## Structure
- Shared package dmem_arb_pkg holds:
  - state encoding (CPU_OWN=2'd0, LDR_SLOT=2'd1, LDR_LOCK=2'd2)
  - grant-owner enum (GNT_NONE, GNT_CPU, GNT_LDR)
- One natural sub-module, dmem_arb_wait_counter: saturating counter with clear/inc/at-limit flag.
- The data memory itself stays outside and is instantiated by the top level.

## Test plan
- CPU idle, loader writes 0xA5 @0x10, then reads 0x10 -> ldr_ready=1 both cycles; ldr_rvalid=1 with ldr_rdata=0xA5 one cycle after the read; cpu_stall never 1.
- CPU cpu_req=1 every cycle, loader read @0x20 with MAX_WAIT=4 -> ldr_ready=0 for 4 cycles; cpu_stall=1 and ldr_ready=1 in cycle 5; CPU owns the memory again in cycle 6.
- CPU write 0x3C @0x05 and loader read @0x05 in the same cycle while the CPU is idle the next cycle -> CPU write commits first; loader gets 0x3C next cycle.
- ldr_lock=1 during a CPU burst -> LDR_LOCK entered after the first idle or forced cycle; cpu_stall held; 8 loader writes accepted back-to-back; cpu_stall=0 one cycle after ldr_lock=0.
- reset_n pulsed low while in LDR_LOCK with a read in flight -> cpu_stall=0, ldr_rvalid=0, and ldr_rdata=0 immediately; state=CPU_OWN after release.
- ldr_valid dropped at wait_cnt=2 then re-raised -> the wait restarts from 0, and the forced slot comes MAX_WAIT cycles after re-raise.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and grant owner.
package dmem_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    LDR_SLOT = 2'd1,
    LDR_LOCK = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_LDR  = 2'd2
  } gnt_e;

endpackage

// File: rtl/dmem_arb_wait_counter.sv
// Saturating loader wait counter; 'last' flags the final wait cycle before saturation.
module dmem_arb_wait_counter #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned W     = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [W-1:0] LIM      = W'(LIMIT);
  localparam logic [W-1:0] LAST_VAL = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == LAST_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, loader gets idle cycles,
// a forced slot after a bounded wait, or exclusive ownership under lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_LINE = 8,
  parameter int unsigned MAX_WAIT     = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDRESS_LINE-1:0] cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_stall,
  input  logic                    ldr_valid,
  input  logic                    ldr_lock,
  input  logic                    ldr_we,
  input  logic [ADDRESS_LINE-1:0] ldr_addr,
  input  logic [DATA_W-1:0]       ldr_wdata,
  output logic                    ldr_ready,
  output logic                    ldr_rvalid,
  output logic [DATA_W-1:0]       ldr_rdata,
  output logic [ADDRESS_LINE-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [DATA_W-1:0]       mem_rdata
);

  arb_state_e state_q, state_d;
  gnt_e       gnt;
  logic       wait_last;

  dmem_arb_wait_counter #(
    .LIMIT (MAX_WAIT),
    .W     (WAIT_W)
  ) u_wait (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (!ldr_valid || ldr_ready),
    .inc     (ldr_valid && !ldr_ready),
    .last    (wait_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CPU_OWN;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant and stall are gated by reset_n so nothing reaches memory during reset.
  always_comb begin
    state_d   = state_q;
    gnt       = GNT_NONE;
    cpu_stall = 1'b0;
    if (reset_n) begin
      case (state_q)
        CPU_OWN: begin
          if (cpu_req) begin
            gnt = GNT_CPU;
          end else if (ldr_valid) begin
            gnt = GNT_LDR;
          end
          if (ldr_lock && !cpu_req) begin
            state_d = LDR_LOCK;
          end else if (ldr_valid && cpu_req && wait_last) begin
            state_d = LDR_SLOT;
          end
        end
        LDR_SLOT: begin
          cpu_stall = 1'b1;
          if (ldr_valid) gnt = GNT_LDR;
          state_d = ldr_lock ? LDR_LOCK : CPU_OWN;
        end
        LDR_LOCK: begin
          cpu_stall = 1'b1;
          if (ldr_valid) gnt = GNT_LDR;
          state_d = ldr_lock ? LDR_LOCK : CPU_OWN;
        end
        default: state_d = CPU_OWN;
      endcase
    end
  end

  assign ldr_ready = (gnt == GNT_LDR);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    case (gnt)
      GNT_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_write = cpu_we;
        mem_read  = !cpu_we;
      end
      GNT_LDR: begin
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        mem_write = ldr_we;
        mem_read  = !ldr_we;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ldr_rvalid <= 1'b0;
      ldr_rdata  <= '0;
    end else if (ldr_ready && !ldr_we) begin
      ldr_rvalid <= 1'b1;
      ldr_rdata  <= mem_rdata;
    end else begin
      ldr_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and a
// read-response scoreboard checked by an independent monitor.
module tb_dmem_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_stall;
  logic       ldr_valid, ldr_lock, ldr_we;
  logic [7:0] ldr_addr, ldr_wdata;
  logic       ldr_ready, ldr_rvalid;
  logic [7:0] ldr_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_write, mem_read;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDRESS_LINE(8), .MAX_WAIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_valid(ldr_valid), .ldr_lock(ldr_lock), .ldr_we(ldr_we),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ready(ldr_ready),
    .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every loader read response must match the queued value.
  always @(negedge clock) begin
    if (reset_n && ldr_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata %0h expected no response at %0t", ldr_rdata, $time);
      end else begin
        check("ldr_rdata", {24'h0, ldr_rdata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Apply one cycle of inputs just after the rising edge; return at the falling edge.
  task automatic step(input logic creq, input logic cwe, input logic [7:0] caddr,
                      input logic [7:0] cwd, input logic lv, input logic lk,
                      input logic lwe, input logic [7:0] laddr, input logic [7:0] lwd);
    @(posedge clock);
    #1;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    ldr_valid = lv; ldr_lock = lk; ldr_we = lwe; ldr_addr = laddr; ldr_wdata = lwd;
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h77;
    reset_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_valid = 1; ldr_lock = 0; ldr_we = 0; ldr_addr = 8'h10; ldr_wdata = 0;

    // Reset: grants suppressed even with a pending loader request
    repeat (2) @(negedge clock);
    check("rst_ready", {31'h0, ldr_ready}, 0);
    check("rst_stall", {31'h0, cpu_stall}, 0);
    check("rst_mem_rd", {31'h0, mem_read}, 0);
    check("rst_mem_wr", {31'h0, mem_write}, 0);
    check("rst_rvalid", {31'h0, ldr_rvalid}, 0);
    check("rst_rdata", {24'h0, ldr_rdata}, 0);
    ldr_valid = 0;
    reset_n = 1'b1;

    // 1: idle CPU, loader write then read
    step(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'hA5);
    check("t1_wr_ready", {31'h0, ldr_ready}, 1);
    check("t1_wr_stall", {31'h0, cpu_stall}, 0);
    check("t1_mem_wr", {31'h0, mem_write}, 1);
    check("t1_mem_addr", {24'h0, mem_addr}, 32'h10);
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00);
    check("t1_rd_ready", {31'h0, ldr_ready}, 1);
    check("t1_mem_rd", {31'h0, mem_read}, 1);
    exp_q.push_back(8'hA5);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    check("t1_rvalid", {31'h0, ldr_rvalid}, 1);
    check("t1_stall_idle", {31'h0, cpu_stall}, 0);

    // 2: busy CPU, forced slot after MAX_WAIT cycles
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 8'h30, 8'h00, 1, 0, 0, 8'h20, 8'h00);
      check("t2_wait_ready", {31'h0, ldr_ready}, 0);
      check("t2_wait_stall", {31'h0, cpu_stall}, 0);
    end
    step(1, 0, 8'h30, 8'h00, 1, 0, 0, 8'h20, 8'h00);
    check("t2_slot_ready", {31'h0, ldr_ready}, 1);
    check("t2_slot_stall", {31'h0, cpu_stall}, 1);
    check("t2_slot_addr", {24'h0, mem_addr}, 32'h20);
    exp_q.push_back(8'h77);
    step(1, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    check("t2_cpu_back_stall", {31'h0, cpu_stall}, 0);
    check("t2_cpu_back_addr", {24'h0, mem_addr}, 32'h30);
    check("t2_cpu_back_rd", {31'h0, mem_read}, 1);

    // 3: CPU write and loader read of the same address
    step(1, 1, 8'h05, 8'h3C, 1, 0, 0, 8'h05, 8'h00);
    check("t3_cpu_first_ready", {31'h0, ldr_ready}, 0);
    check("t3_cpu_wr", {31'h0, mem_write}, 1);
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h05, 8'h00);
    check("t3_ldr_ready", {31'h0, ldr_ready}, 1);
    exp_q.push_back(8'h3C);

    // 4: lock requested during a CPU burst, entered at the first idle cycle
    step(1, 0, 8'h31, 8'h00, 0, 1, 0, 8'h00, 8'h00);
    check("t4_busy_stall", {31'h0, cpu_stall}, 0);
    step(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00);
    check("t4_idle_stall", {31'h0, cpu_stall}, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'h31, 8'h00, 1, 1, 1, 8'h40 + 8'(i), 8'h50 + 8'(i));
      check("t4_lock_stall", {31'h0, cpu_stall}, 1);
      check("t4_lock_ready", {31'h0, ldr_ready}, 1);
    end
    step(1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    check("t4_unlock_stall", {31'h0, cpu_stall}, 1);
    step(1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    check("t4_release_stall", {31'h0, cpu_stall}, 0);
    check("t4_release_addr", {24'h0, mem_addr}, 32'h31);
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h43, 8'h00);
    check("t4_readback_ready", {31'h0, ldr_ready}, 1);
    exp_q.push_back(8'h53);

    // 5: reset in lock with a read response pending
    step(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00);
    step(1, 0, 8'h32, 8'h00, 1, 1, 0, 8'h10, 8'h00);
    check("t5_lock_ready", {31'h0, ldr_ready}, 1);
    check("t5_lock_stall", {31'h0, cpu_stall}, 1);
    @(posedge clock);
    #1;
    ldr_valid = 0;
    reset_n = 1'b0;
    #1;
    check("t5_rst_stall", {31'h0, cpu_stall}, 0);
    check("t5_rst_rvalid", {31'h0, ldr_rvalid}, 0);
    check("t5_rst_rdata", {24'h0, ldr_rdata}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1, 0, 8'h32, 8'h00, 0, 1, 0, 8'h00, 8'h00);
    check("t5_post_stall", {31'h0, cpu_stall}, 0);
    check("t5_post_addr", {24'h0, mem_addr}, 32'h32);
    step(1, 0, 8'h32, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    // 6: loader drops valid at wait_cnt=2; wait restarts on re-raise
    step(1, 0, 8'h33, 8'h00, 1, 0, 0, 8'h20, 8'h00);
    step(1, 0, 8'h33, 8'h00, 1, 0, 0, 8'h20, 8'h00);
    step(1, 0, 8'h33, 8'h00, 0, 0, 0, 8'h20, 8'h00);
    check("t6_drop_stall", {31'h0, cpu_stall}, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 8'h33, 8'h00, 1, 0, 0, 8'h20, 8'h00);
      check("t6_rewait_ready", {31'h0, ldr_ready}, 0);
      check("t6_rewait_stall", {31'h0, cpu_stall}, 0);
    end
    step(1, 0, 8'h33, 8'h00, 1, 0, 0, 8'h20, 8'h00);
    check("t6_slot_ready", {31'h0, ldr_ready}, 1);
    check("t6_slot_stall", {31'h0, cpu_stall}, 1);
    exp_q.push_back(8'h77);

    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
